// File: rtl/inst_image_loader.sv
// rtl/inst_image_loader.sv - copies a program image into instruction RAM and holds the CPU in reset until done
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   img             program image, word 0 at index 0, stable while busy
//   start           pulse to begin a copy (honoured in IDLE and DONE)
//   wr_valid/ready  instruction RAM write handshake, wr_addr/wr_data payload
//   busy, done, err copy in progress / finished / finished without sentinel
//   count           words accepted by the RAM in the current or last copy
//   cpu_hold        1 keeps the core in reset
module inst_image_loader #(
    parameter int          DEPTH     = 200,
    parameter int          ADDR_W    = 8,
    parameter int          BASE_ADDR = 0,
    parameter logic [31:0] END_WORD  = 32'hffffffff,
    localparam int         CNT_W     = $clog2(DEPTH + 1),
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       img [DEPTH],
    input  logic              start,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  count,
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                cpu_hold_q, cpu_hold_d;

    logic [IDX_W-1:0]    idx_nxt;

    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        cpu_hold_d = cpu_hold_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    idx_d      = '0;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ADDR_W'(BASE_ADDR);
                    wr_data_d  = img[0];
                    count_d    = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (wr_valid_q && wr_ready) begin
                    count_d = count_q + CNT_W'(1);
                    if (wr_data_q == END_WORD || idx_q == IDX_W'(DEPTH - 1)) begin
                        // The sentinel wins over running out of image, so a
                        // sentinel in the last slot still finishes cleanly.
                        state_d    = ST_DONE;
                        err_d      = (wr_data_q != END_WORD);
                        wr_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        idx_d     = idx_nxt;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        wr_data_d = img[idx_nxt];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= ADDR_W'(BASE_ADDR);
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;
    assign cpu_hold = cpu_hold_q;

endmodule
